// File: rtl/st_fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised Avalon-ST FIFO.
package st_fifo_pkg;

  // Pointer storage width; the FIFO uses only the low ADDR_WIDTH bits and
  // keeps the upper bits at zero through masking.
  localparam int PTR_W = 16;

  typedef logic [PTR_W-1:0] ptr_t;

  // Control state of the FIFO: pointers plus explicit full/empty flags.
  typedef struct packed {
    ptr_t wr_ptr;
    ptr_t rd_ptr;
    logic empty;
    logic full;
  } fifo_ctrl_t;

  // Control state after reset or flush.
  localparam fifo_ctrl_t CTRL_RESET = '{
    wr_ptr: '0,
    rd_ptr: '0,
    empty:  1'b1,
    full:   1'b0
  };

  // Ceiling log2, used to validate DEPTH against ADDR_WIDTH.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v / 32'sd2;
    end
    return result;
  endfunction

  // Stored word width: payload plus sop/eop when packet sideband is enabled.
  function automatic int word_width(input int data_width, input int use_packets);
    return (use_packets != 32'sd0) ? (data_width + 32'sd2) : data_width;
  endfunction

endpackage

// File: rtl/st_fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port and one registered
// read port, written so that it maps onto a block RAM.
module st_fifo_ram #(
  parameter int WIDTH      = 44,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: store the incoming word when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; no reset so the register folds into the RAM
  // primitive. Contents are only meaningful when the FIFO flags them valid.
  always_ff @(posedge clk) begin
    rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/st_param_fifo.sv
// Parametrised single-clock Avalon-ST FIFO with optional packet sideband,
// almost-full/almost-empty flags, synchronous flush and a count of eop
// words held. Control, counters and flags live here; storage is in
// st_fifo_ram.
module st_param_fifo
  import st_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 42,
  parameter int DEPTH           = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int USE_PACKETS     = 0,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int WORD_W = word_width(DATA_WIDTH, USE_PACKETS);
  localparam int CNT_W  = ADDR_WIDTH + 1;

  localparam ptr_t             PTR_MASK = ptr_t'(DEPTH - 32'sd1);
  localparam ptr_t             PTR_ONE  = ptr_t'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] AF_TH    = CNT_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0] AE_TH    = CNT_W'(ALMOST_EMPTY_TH);

  // Reject inconsistent geometry at elaboration time.
  if ((DEPTH < 32'sd4) || ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0)) begin : g_bad_depth
    $error("st_param_fifo: DEPTH must be a power of two and at least 4");
  end
  if (ADDR_WIDTH != clog2(DEPTH)) begin : g_bad_addr
    $error("st_param_fifo: ADDR_WIDTH must equal log2(DEPTH)");
  end
  if (ADDR_WIDTH > PTR_W) begin : g_bad_ptr
    $error("st_param_fifo: ADDR_WIDTH exceeds pointer storage width");
  end

  fifo_ctrl_t       ctrl_r;
  fifo_ctrl_t       ctrl_nxt_s;
  ptr_t             next_wr_s;
  ptr_t             next_rd_s;
  ptr_t             mem_rd_addr_s;
  logic             push_s;
  logic             pop_s;
  logic             we_s;
  logic             push_eop_s;
  logic             pop_eop_s;
  logic [CNT_W-1:0] fill_r;
  logic [CNT_W-1:0] fill_nxt_s;
  logic [CNT_W-1:0] pkt_r;
  logic [CNT_W-1:0] pkt_nxt_s;
  logic             out_valid_r;
  logic             out_valid_nxt_s;
  logic             af_r;
  logic             ae_r;
  logic [WORD_W-1:0] wr_word_s;
  logic [WORD_W-1:0] rd_word_s;

  // Handshake qualifiers. A word offered while full is simply not taken.
  assign in_ready  = ~ctrl_r.full;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid_r & out_ready;

  // A word accepted during a flush is dropped rather than stored.
  assign we_s      = push_s & ~flush;

  // Pointer increments wrap modulo DEPTH.
  assign next_wr_s = (ctrl_r.wr_ptr + PTR_ONE) & PTR_MASK;
  assign next_rd_s = (ctrl_r.rd_ptr + PTR_ONE) & PTR_MASK;

  // Look ahead one word on a pop so consecutive pops see no bubble.
  assign mem_rd_addr_s = pop_s ? next_rd_s : ctrl_r.rd_ptr;

  // Packet sideband is stored above the payload only when enabled.
  if (USE_PACKETS != 32'sd0) begin : g_pkt
    assign wr_word_s  = {in_eop, in_sop, in_data};
    assign out_sop    = rd_word_s[DATA_WIDTH];
    assign out_eop    = rd_word_s[DATA_WIDTH+1];
    assign push_eop_s = push_s & in_eop;
  end else begin : g_no_pkt
    logic unused_pkt_s;
    assign unused_pkt_s = in_sop ^ in_eop;
    assign wr_word_s    = in_data;
    assign out_sop      = 1'b0;
    assign out_eop      = 1'b0;
    assign push_eop_s   = 1'b0;
  end

  assign pop_eop_s = pop_s & out_eop;
  assign out_data  = rd_word_s[DATA_WIDTH-1:0];

  st_fifo_ram #(
    .WIDTH      (WORD_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (we_s),
    .wr_addr (ctrl_r.wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_word_s),
    .rd_addr (mem_rd_addr_s[ADDR_WIDTH-1:0]),
    .rd_data (rd_word_s)
  );

  // Next state of pointers, flags, fill level, packet count and out_valid.
  always_comb begin
    ctrl_nxt_s      = ctrl_r;
    fill_nxt_s      = fill_r;
    pkt_nxt_s       = pkt_r;
    out_valid_nxt_s = 1'b0;
    if (flush) begin
      ctrl_nxt_s      = CTRL_RESET;
      fill_nxt_s      = '0;
      pkt_nxt_s       = '0;
      out_valid_nxt_s = 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          ctrl_nxt_s.wr_ptr = next_wr_s;
          ctrl_nxt_s.empty  = 1'b0;
          ctrl_nxt_s.full   = (next_wr_s == ctrl_r.rd_ptr);
          fill_nxt_s        = fill_r + CNT_ONE;
        end
        2'b01: begin
          ctrl_nxt_s.rd_ptr = next_rd_s;
          ctrl_nxt_s.full   = 1'b0;
          ctrl_nxt_s.empty  = (next_rd_s == ctrl_r.wr_ptr);
          fill_nxt_s        = fill_r - CNT_ONE;
        end
        2'b11: begin
          // Both pointers advance; occupancy and flags are unchanged.
          ctrl_nxt_s.wr_ptr = next_wr_s;
          ctrl_nxt_s.rd_ptr = next_rd_s;
        end
        default: begin
          ctrl_nxt_s = ctrl_r;
        end
      endcase

      case ({push_eop_s, pop_eop_s})
        2'b10:   pkt_nxt_s = pkt_r + CNT_ONE;
        2'b01:   pkt_nxt_s = pkt_r - CNT_ONE;
        default: pkt_nxt_s = pkt_r;
      endcase

      // The read register samples memory as it was before this edge, so a
      // word written on this same edge cannot be shown yet. The word at the
      // read address is valid unless the FIFO is empty or this pop takes the
      // last stored word.
      if (ctrl_r.empty) begin
        out_valid_nxt_s = 1'b0;
      end else if (pop_s && (next_rd_s == ctrl_r.wr_ptr)) begin
        out_valid_nxt_s = 1'b0;
      end else begin
        out_valid_nxt_s = 1'b1;
      end
    end
  end

  // Control and status registers; thresholds use the next fill level so the
  // flags line up with fill_level in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r      <= CTRL_RESET;
      fill_r      <= '0;
      pkt_r       <= '0;
      out_valid_r <= 1'b0;
      af_r        <= 1'b0;
      ae_r        <= 1'b1;
    end else begin
      ctrl_r      <= ctrl_nxt_s;
      fill_r      <= fill_nxt_s;
      pkt_r       <= pkt_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      af_r        <= (fill_nxt_s >= AF_TH);
      ae_r        <= (fill_nxt_s <= AE_TH);
    end
  end

  assign out_valid    = out_valid_r;
  assign fill_level   = fill_r;
  assign pkt_count    = pkt_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;

endmodule

// File: tb/tb_st_param_fifo.sv
// Self-checking bench for st_param_fifo (DEPTH=16, packets enabled).
module tb_st_param_fifo;

  localparam int DW    = 42;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic [AW:0]   fill_level;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   pkt_count;

  always #5 clk = ~clk;

  st_param_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .USE_PACKETS(1),
    .ALMOST_FULL_TH(12), .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .fill_level(fill_level), .almost_full(almost_full),
    .almost_empty(almost_empty), .pkt_count(pkt_count)
  );

  // Scoreboard entry: a stored word and the edge at which it was accepted.
  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
    int            edge_n;
  } ent_t;

  // Table record: stimulus for one cycle plus the expected status after it.
  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    int            exp_fill;
    int            exp_ovalid;
    int            exp_rdy;
    int            exp_af;
    int            exp_ae;
  } vec_t;

  ent_t q[$];
  vec_t vecs[$];
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A word is visible once it was accepted at an edge before the latest one.
  function automatic logic model_ovalid();
    return (q.size() > 0) && (q[0].edge_n < edge_cnt);
  endfunction

  task automatic check_all();
    int  pk;
    logic mv;
    pk = 0;
    foreach (q[i]) if (q[i].e) pk = pk + 1;
    mv = model_ovalid();
    chk("in_ready",     64'(in_ready),     64'(q.size() < DEPTH));
    chk("out_valid",    64'(out_valid),    64'(mv));
    chk("fill_level",   64'(fill_level),   64'(q.size()));
    chk("almost_full",  64'(almost_full),  64'(q.size() >= 12));
    chk("almost_empty", 64'(almost_empty), 64'(q.size() <= 2));
    chk("pkt_count",    64'(pkt_count),    64'(pk));
    if (mv) begin
      chk("out_data", 64'(out_data), 64'(q[0].d));
      chk("out_sop",  64'(out_sop),  64'(q[0].s));
      chk("out_eop",  64'(out_eop),  64'(q[0].e));
    end
  endtask

  // One clock of stimulus; the scoreboard follows the handshake, then all
  // outputs are compared 1 time unit after the edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic s,
                      input logic e, input logic ordy, input logic fl);
    logic m_push;
    logic m_pop;
    in_valid  = iv;
    in_data   = d;
    in_sop    = s;
    in_eop    = e;
    out_ready = ordy;
    flush     = fl;
    m_push = iv && (q.size() < DEPTH);
    m_pop  = model_ovalid() && ordy;
    @(posedge clk);
    edge_cnt = edge_cnt + 1;
    if (fl) begin
      q.delete();
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back('{d: d, s: s, e: e, edge_n: edge_cnt});
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    check_all();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0) && (n < 64)) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      n = n + 1;
    end
    if (q.size() != 0) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL drain_timeout: %0d words left, expected 0", q.size());
    end
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      step(vecs[k].iv, vecs[k].d, 1'b0, 1'b0, vecs[k].ordy, 1'b0);
      chk("tbl_fill",      64'(fill_level),   64'(vecs[k].exp_fill));
      chk("tbl_out_valid", 64'(out_valid),    64'(vecs[k].exp_ovalid));
      chk("tbl_in_ready",  64'(in_ready),     64'(vecs[k].exp_rdy));
      chk("tbl_af",        64'(almost_full),  64'(vecs[k].exp_af));
      chk("tbl_ae",        64'(almost_empty), 64'(vecs[k].exp_ae));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: fill 16 words, drain 16 words, then single-word latency.
    for (int i = 0; i < 16; i++)
      vecs.push_back('{iv: 1'b1, d: DW'(i), ordy: 1'b0, exp_fill: i + 1,
                       exp_ovalid: (i >= 1) ? 1 : 0, exp_rdy: (i < 15) ? 1 : 0,
                       exp_af: (i + 1 >= 12) ? 1 : 0, exp_ae: (i + 1 <= 2) ? 1 : 0});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{iv: 1'b0, d: '0, ordy: 1'b1, exp_fill: 15 - i,
                       exp_ovalid: (i < 15) ? 1 : 0, exp_rdy: 1,
                       exp_af: (15 - i >= 12) ? 1 : 0, exp_ae: (15 - i <= 2) ? 1 : 0});
    vecs.push_back('{iv: 1'b1, d: 42'h2A, ordy: 1'b0, exp_fill: 1, exp_ovalid: 0,
                     exp_rdy: 1, exp_af: 0, exp_ae: 1});
    vecs.push_back('{iv: 1'b0, d: '0, ordy: 1'b0, exp_fill: 1, exp_ovalid: 1,
                     exp_rdy: 1, exp_af: 0, exp_ae: 1});
    vecs.push_back('{iv: 1'b0, d: '0, ordy: 1'b1, exp_fill: 0, exp_ovalid: 0,
                     exp_rdy: 1, exp_af: 0, exp_ae: 1});

    // Reset state, checked before any clock edge.
    #1 reset_n = 1'b0;
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Full then drain.
    apply_range(0, 16);
    chk("full_head_data", 64'(out_data), 64'(0));
    apply_range(16, 32);
    // First-word latency.
    apply_range(32, 33);
    chk("latency_not_early", 64'(out_valid), 64'(0));
    apply_range(33, 34);
    chk("latency_data", 64'(out_data), 64'(42'h2A));
    apply_range(34, 35);

    // Steady push+pop at fill 5 across several pointer wraps.
    for (int k = 0; k < 5; k++) step(1'b1, DW'(1000 + k), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 5; k < 45; k++) begin
      step(1'b1, DW'(1000 + k), 1'b0, 1'b0, 1'b1, 1'b0);
      chk("wrap_fill", 64'(fill_level), 64'(5));
    end
    drain();

    // Packets of 3, 1 and 4 words.
    begin
      int lens[3];
      int w;
      lens[0] = 3; lens[1] = 1; lens[2] = 4;
      w = 0;
      for (int p = 0; p < 3; p++)
        for (int k = 0; k < lens[p]; k++) begin
          step(1'b1, DW'(2000 + w), (k == 0), (k == lens[p] - 1), 1'b0, 1'b0);
          w = w + 1;
        end
    end
    chk("pkt_count_3", 64'(pkt_count), 64'(3));
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pkt_count_2", 64'(pkt_count), 64'(2));
    chk("single_pkt_sop", 64'(out_sop), 64'(1));
    chk("single_pkt_eop", 64'(out_eop), 64'(1));
    drain();

    // Flush with a word offered and a pop in the same cycle.
    for (int k = 0; k < 9; k++) step(1'b1, DW'(3000 + k), 1'b0, (k % 3 == 2), 1'b0, 1'b0);
    chk("pre_flush_fill", 64'(fill_level), 64'(9));
    chk("pre_flush_pkt", 64'(pkt_count), 64'(3));
    step(1'b1, 42'h3DEAD, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush_fill", 64'(fill_level), 64'(0));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_pkt", 64'(pkt_count), 64'(0));
    step(1'b1, DW'(3100), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(3101), 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Asynchronous reset in the middle of traffic.
    for (int k = 0; k < 4; k++) step(1'b1, DW'(4000 + k), 1'b0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_fill", 64'(fill_level), 64'(0));
    chk("rst_pkt", 64'(pkt_count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_ae", 64'(almost_empty), 64'(1));
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, DW'(5000 + k), 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
